bit_serial_adder: RTL and testbench



---
 rtl/bsa_pkg.sv | 12 +
 rtl/FA.sv | 14 +
 rtl/bit_serial_adder.sv | 110 +++++++++++
 tb/tb_bit_serial_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared state encoding and default width for bit_serial_adder
package bsa_pkg;

    localparam int BSA_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } bsa_state_e;

endpackage

// File: rtl/FA.sv
// rtl/FA.sv - single-bit full adder cell
// Ports: A, B, Cin inputs; Sum, Cout outputs.
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - N-bit adder that reuses one FA cell, one bit per clock, LSB first
// Ports: clk, rst (sync active-high), start, a, b, cin in; busy, done, sum, cout out.
// An accepted start loads the operands, then N ADD cycles shift one result bit
// per clock into sum_sh; the result registers load on the last ADD edge and
// done pulses for one cycle in DONE.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int N = BSA_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    bsa_state_e     state_q;
    logic [N-1:0]   a_sh_q;
    logic [N-1:0]   b_sh_q;
    logic [N-1:0]   sum_sh_q;
    logic           carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [N-1:0]   sum_q;
    logic           cout_q;

    logic           fa_sum;
    logic           fa_cout;
    logic [N-1:0]   sum_sh_d;

    FA u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // New bit enters at the MSB so after N shifts bit 0 sits at the LSB.
    assign sum_sh_d = {fa_sum, sum_sh_q[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ADD;
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ADD: begin
                    sum_sh_q <= sum_sh_d;
                    a_sh_q   <= {1'b0, a_sh_q[N-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[N-1:1]};
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    // Last bit: capture the result straight from the FA
                    // so it is visible together with done.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        sum_q   <= sum_sh_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - scoreboard bench for bit_serial_adder
`timescale 1ns/1ps
module tb_bit_serial_adder;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int done_cnt   = 0;

    logic [N:0] exp_q[$];
    int         acc_q[$];
    logic [N:0] held = '0;
    logic [N:0] m_exp;
    int         m_acc;

    bit_serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one sample per clock, 1 ns after the rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            held = '0;
        end else if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_exp = exp_q.pop_front();
                m_acc = acc_q.pop_front();
                check("sum", 32'(sum), 32'(m_exp[N-1:0]));
                check("cout", 32'(cout), 32'(m_exp[N]));
                check("done_latency", 32'(cyc - m_acc), 32'(N));
                held = m_exp;
            end
        end else begin
            check("result_hold", 32'({cout, sum}), 32'(held));
        end
    end

    // Called on the negedge that drives start: the accept edge is the next one.
    task automatic push_exp(input logic [N:0] e);
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
    endtask

    task automatic wait_done(input int target, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 40 && done_cnt < target; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
        end
        if (done_cnt < target) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                      input logic [N:0] e, output int busy_n);
        @(negedge clk);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        push_exp(e);
        wait_done(done_cnt + 1, busy_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bn;
        int tgt;
        logic [N-1:0] rx;
        logic [N-1:0] ry;
        logic         rc;
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        logic         tc [4];
        logic [N:0]   te [4];

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // 1: basic add, latency and busy length
        op(8'h5A, 8'h3C, 1'b0, 9'h096, bn);
        check("t1_busy_cycles", 32'(bn), 32'd9);

        // 2: carry out and full carry chain
        op(8'hFF, 8'h01, 1'b0, 9'h100, bn);
        op(8'hFF, 8'hFF, 1'b1, 9'h1FF, bn);

        // 3: start pulses during ADD cycle 3 and during DONE are ignored
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        push_exp(9'h030);
        tgt = done_cnt + 1;
        @(negedge clk);
        start = 1'b0; a = 8'hAA; b = 8'h55;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_done_cycle", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("t3_single_done", 32'(done_cnt), 32'(tgt));
        check("t3_idle", 32'(busy), 32'd0);

        // 4: start held high, accepts every N+2 cycles
        ta[0] = 8'h12; tb[0] = 8'h34; tc[0] = 1'b0; te[0] = 9'h046;
        ta[1] = 8'hC8; tb[1] = 8'h64; tc[1] = 1'b1; te[1] = 9'h12D;
        ta[2] = 8'h80; tb[2] = 8'h80; tc[2] = 1'b0; te[2] = 9'h100;
        ta[3] = 8'h01; tb[3] = 8'hFE; tc[3] = 1'b1; te[3] = 9'h100;
        tgt = done_cnt + 4;
        @(negedge clk);
        a = ta[0]; b = tb[0]; cin = tc[0]; start = 1'b1;
        push_exp(te[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            a = ta[i]; b = tb[i]; cin = tc[i];
            exp_q.push_back(te[i]);
            acc_q.push_back(acc_q[acc_q.size() - 1] + N + 2);
            repeat (N + 1) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt, bn);

        // 5: reset in ADD cycle 4 discards the operation
        @(negedge clk);
        a = 8'h0F; b = 8'hF1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_sum", 32'(sum), 32'd0);
        check("t5_cout", 32'(cout), 32'd0);
        tgt = done_cnt;
        repeat (12) @(negedge clk);
        check("t5_no_done", 32'(done_cnt), 32'(tgt));
        op(8'h01, 8'h01, 1'b0, 9'h002, bn);

        // 6: reset wins over start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h44;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("t6_idle", 32'(busy), 32'd0);
        tgt = done_cnt;
        repeat (12) @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'(tgt));

        // Random regression against a + b + cin
        for (int i = 0; i < 300; i++) begin
            rx = N'($urandom_range(0, 255));
            ry = N'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            op(rx, ry, rc, {1'b0, rx} + {1'b0, ry} + {{N{1'b0}}, rc}, bn);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
